// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, ghost rejection and a four-digit
// hex entry register that shifts in each accepted key.
module keypad_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Col,
  input  logic        Clear,
  output logic [3:0]  Row,
  output logic        KeyValid,
  output logic [3:0]  KeyCode,
  output logic [15:0] Value,
  output logic [2:0]  Count
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] STABLE_LAST = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state;
  logic [3:0]      col_meta;
  logic [3:0]      col_s;
  logic [3:0]      col_pat;
  logic [1:0]      idx;
  logic [1:0]      col_idx;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   stable_cnt;
  logic            single_low;
  logic [1:0]      col_enc;

  // Idle columns read high, so the synchronizer resets to "no key".
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col_meta <= 4'b1111;
      col_s    <= 4'b1111;
    end else begin
      col_meta <= Col;
      col_s    <= col_meta;
    end
  end

  assign Row = ~(4'b0001 << idx);

  // Only a single low column is a key; anything else (none or several) is ignored.
  always_comb begin
    single_low = 1'b1;
    col_enc    = 2'd0;
    case (col_s)
      4'b1110: col_enc = 2'd0;
      4'b1101: col_enc = 2'd1;
      4'b1011: col_enc = 2'd2;
      4'b0111: col_enc = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= SCAN;
      idx        <= 2'd0;
      col_idx    <= 2'd0;
      col_pat    <= 4'b1111;
      scan_cnt   <= '0;
      stable_cnt <= '0;
      KeyValid   <= 1'b0;
      KeyCode    <= 4'd0;
      Value      <= 16'd0;
      Count      <= 3'd0;
    end else begin
      KeyValid <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (single_low) begin
              col_pat    <= col_s;
              col_idx    <= col_enc;
              stable_cnt <= '0;
              state      <= DEBOUNCE;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s == col_pat) begin
            if (stable_cnt == STABLE_LAST) begin
              stable_cnt <= '0;
              state      <= HELD;
              KeyValid   <= 1'b1;
              KeyCode    <= {idx, col_idx};
              Value      <= {Value[11:0], idx, col_idx};
              Count      <= (Count == 3'd4) ? Count : Count + 3'd1;
            end else begin
              stable_cnt <= stable_cnt + DW'(1);
            end
          end else begin
            stable_cnt <= '0;
            idx        <= idx + 2'd1;
            state      <= SCAN;
          end
        end
        HELD: begin
          if (col_s == 4'b1111) begin
            stable_cnt <= '0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          // A low column during release debounce means the key bounced back.
          if (col_s == 4'b1111) begin
            if (stable_cnt == STABLE_LAST) begin
              stable_cnt <= '0;
              idx        <= idx + 2'd1;
              state      <= SCAN;
            end else begin
              stable_cnt <= stable_cnt + DW'(1);
            end
          end else begin
            state <= HELD;
          end
        end
        default: state <= SCAN;
      endcase
      if (Clear) begin
        Value <= 16'd0;
        Count <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a physical 4x4 keypad model answers the row drive,
// and an entry-register model predicts KeyCode, Value and Count.
module tb_keypad_entry;

  localparam int SD  = 4;
  localparam int DC  = 3;
  localparam int LAT = 4 * SD + DC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;
  logic [2:0]  count;

  logic [15:0] keys;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [15:0] exp_value;
  logic [2:0]  exp_count;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .Clk(clk), .Reset(rst), .Col(col), .Clear(clear),
    .Row(row), .KeyValid(key_valid), .KeyCode(key_code),
    .Value(value), .Count(count)
  );

  always #5 clk = ~clk;

  // A pressed switch pulls its column low only while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic void model_accept(input logic [3:0] code);
    exp_value = {exp_value[11:0], code};
    exp_count = (exp_count >= 3'd4) ? 3'd4 : exp_count + 3'd1;
  endfunction

  task automatic press_and_wait(input int r, input int c, input int budget, output bit got);
    int start;
    start = pulses;
    got = 1'b0;
    keys[r*4+c] = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pulses != start) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_all();
    keys = '0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; keys = '0;
    exp_value = '0; exp_count = '0;
    repeat (3) tick();
    checks++; if (row !== 4'b1110) begin errors++; $display("[TB] FAIL reset_row got %b expected 1110", row); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code got %h expected 0", key_code); end
    checks++; if (value !== 16'h0) begin errors++; $display("[TB] FAIL reset_value got %h expected 0", value); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
  endtask

  task automatic test_scan();
    int start;
    logic [3:0] exp_row;
    start = pulses;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_row = ~(4'b0001 << ((k / SD) % 4));
      checks++;
      if (row !== exp_row) begin
        errors++; $display("[TB] FAIL scan_row edge %0d got %b expected %b", k, row, exp_row);
      end
    end
    checks++; if (pulses != start) begin errors++; $display("[TB] FAIL scan_no_pulse got %0d expected 0", pulses - start); end
  endtask

  task automatic test_single_key();
    bit got;
    int start;
    start = pulses;
    press_and_wait(1, 2, LAT, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL single_latency got none expected pulse within %0d", LAT); end
    model_accept(4'h6);
    checks++; if (key_code !== 4'h6) begin errors++; $display("[TB] FAIL single_code got %h expected 6", key_code); end
    checks++; if (value !== exp_value) begin errors++; $display("[TB] FAIL single_value got %h expected %h", value, exp_value); end
    checks++; if (count !== exp_count) begin errors++; $display("[TB] FAIL single_count got %0d expected %0d", count, exp_count); end
    repeat (200) tick();
    checks++; if (pulses - start != 1) begin errors++; $display("[TB] FAIL single_no_repeat got %0d expected 1", pulses - start); end
    release_all();
    clear = 1'b1; tick(); clear = 1'b0;
    exp_value = '0; exp_count = '0;
    checks++; if (value !== 16'h0 || count !== 3'd0) begin errors++; $display("[TB] FAIL clear_idle got %h/%0d expected 0/0", value, count); end
  endtask

  task automatic test_sequence();
    bit got;
    for (int k = 1; k <= 5; k++) begin
      press_and_wait(k / 4, k % 4, LAT, got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL seq_latency key %0d got none", k); end
      model_accept(4'(k));
      checks++; if (value !== exp_value) begin errors++; $display("[TB] FAIL seq_value key %0d got %h expected %h", k, value, exp_value); end
      repeat (5) tick();
      release_all();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL seq_count got %0d expected 4", count); end
    checks++; if (value !== 16'h2345) begin errors++; $display("[TB] FAIL seq_final got %h expected 2345", value); end
  endtask

  task automatic test_bounce();
    bit got;
    int start;
    start = pulses;
    for (int i = 0; i < 4 * SD + 2 && row !== 4'b1011; i++) tick();
    keys[11] = 1'b1; repeat (2) tick();
    keys[11] = 1'b0; tick();
    press_and_wait(2, 3, 3 * LAT, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL bounce_press got none expected pulse"); end
    model_accept(4'hB);
    checks++; if (key_code !== 4'hB) begin errors++; $display("[TB] FAIL bounce_code got %h expected b", key_code); end
    repeat (10) tick();
    keys[11] = 1'b0; tick();
    keys[11] = 1'b1; repeat (2) tick();
    release_all();
    repeat (3 * LAT) tick();
    checks++; if (pulses - start != 1) begin errors++; $display("[TB] FAIL bounce_pulses got %0d expected 1", pulses - start); end
    checks++; if (value !== exp_value) begin errors++; $display("[TB] FAIL bounce_value got %h expected %h", value, exp_value); end
  endtask

  task automatic test_ghost();
    int start;
    start = pulses;
    keys[13] = 1'b1; keys[14] = 1'b1;
    repeat (100) tick();
    checks++; if (pulses != start) begin errors++; $display("[TB] FAIL ghost_pulse got %0d expected 0", pulses - start); end
    checks++; if (value !== exp_value) begin errors++; $display("[TB] FAIL ghost_value got %h expected %h", value, exp_value); end
    release_all();
  endtask

  task automatic test_clear_collision();
    bit got;
    clear = 1'b1;
    press_and_wait(3, 0, LAT, got);
    clear = 1'b0;
    exp_value = '0; exp_count = '0;
    checks++; if (!got) begin errors++; $display("[TB] FAIL collide_latency got none expected pulse"); end
    checks++; if (key_code !== 4'hC) begin errors++; $display("[TB] FAIL collide_code got %h expected c", key_code); end
    checks++; if (value !== 16'h0) begin errors++; $display("[TB] FAIL collide_value got %h expected 0", value); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL collide_count got %0d expected 0", count); end
    release_all();
  endtask

  task automatic test_random();
    bit got;
    int r, c;
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      press_and_wait(r, c, LAT, got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL rand_latency iter %0d got none", n); end
      model_accept(4'(r * 4 + c));
      checks++; if (key_code !== 4'(r * 4 + c)) begin errors++; $display("[TB] FAIL rand_code iter %0d got %h expected %h", n, key_code, 4'(r * 4 + c)); end
      checks++; if (value !== exp_value || count !== exp_count) begin
        errors++; $display("[TB] FAIL rand_entry iter %0d got %h/%0d expected %h/%0d", n, value, count, exp_value, exp_count);
      end
      repeat ($urandom_range(0, 30)) tick();
      release_all();
      if ($urandom_range(0, 2) == 0) begin
        clear = 1'b1; tick(); clear = 1'b0;
        exp_value = '0; exp_count = '0;
        checks++; if (value !== 16'h0 || count !== 3'd0) begin errors++; $display("[TB] FAIL rand_clear iter %0d got %h/%0d expected 0/0", n, value, count); end
      end
    end
  endtask

  task automatic test_reset_held();
    bit got;
    int start;
    press_and_wait(1, 1, LAT, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL held_first got none expected pulse"); end
    repeat (5) tick();
    start = pulses;
    rst = 1'b1;
    #1;
    exp_value = '0; exp_count = '0;
    checks++; if (row !== 4'b1110 || key_valid !== 1'b0) begin errors++; $display("[TB] FAIL held_reset_row got %b/%b expected 1110/0", row, key_valid); end
    checks++; if (key_code !== 4'h0 || value !== 16'h0 || count !== 3'd0) begin
      errors++; $display("[TB] FAIL held_reset_regs got %h/%h/%0d expected 0/0/0", key_code, value, count);
    end
    keys = '0;
    repeat (5) tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (pulses != start) begin errors++; $display("[TB] FAIL held_no_pulse got %0d expected 0", pulses - start); end
    press_and_wait(1, 1, LAT, got);
    model_accept(4'h5);
    checks++; if (!got || key_code !== 4'h5) begin errors++; $display("[TB] FAIL held_repress got %h expected 5", key_code); end
    repeat (30) tick();
    release_all();
    checks++; if (pulses - start != 1) begin errors++; $display("[TB] FAIL held_pulses got %0d expected 1", pulses - start); end
    checks++; if (value !== exp_value || count !== exp_count) begin
      errors++; $display("[TB] FAIL held_entry got %h/%0d expected %h/%0d", value, count, exp_value, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_single_key();
    test_sequence();
    test_bounce();
    test_ghost();
    test_clear_collision();
    test_random();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, 1000, clock cycles each row is driven before its columns are sampled (>=4).
REQ-002 Parameter DEBOUNCE_CNT, 20, consecutive stable samples required for press or release (>=1).
REQ-003 Clk  input  1  system clock; the only clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Col  input  4  raw keypad columns, active-low, asynchronous to Clk.
REQ-006 Clear  input  1  synchronous, active-high clear of the entry value.
REQ-007 Row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-008 KeyValid  output  1  one-cycle pulse per accepted key press.
REQ-009 KeyCode  output  4  code of the last accepted key.
REQ-010 Value  output  16  hex entry value, four digits, feeds datapath/display.
REQ-011 Count  output  3  digits entered since the last clear, saturating at 4.

Function
REQ-012 Col SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (colS).
REQ-013 Row index idx (0..3) SHALL drive Row = ~(4'b0001 << idx).
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: count SCAN_DIV cycles on current idx; on last cycle sample colS; exactly one bit low -> latch idx and column index, go DEBOUNCE; else idx <= idx+1 (3 wraps to 0), stay SCAN.
REQ-016 SCAN with two or more colS bits low SHALL be treated as no key (ghosting rejection).
REQ-017 DEBOUNCE: Row held; each cycle colS equals latched pattern -> stable counter +1; any mismatch -> counter cleared, idx advanced, return to SCAN.
REQ-018 DEBOUNCE reaching DEBOUNCE_CNT matches SHALL go HELD and assert KeyValid for exactly that one cycle.
REQ-019 KeyCode SHALL equal {row idx[1:0], column idx[1:0]}, updated in the KeyValid cycle, held otherwise.
REQ-020 On KeyValid Value SHALL become {Value[11:0], KeyCode}; Count increments, saturating at 4; the oldest digit is discarded.
REQ-021 HELD: wait for colS == 4'b1111; then go RELEASE with counter cleared.
REQ-022 RELEASE: DEBOUNCE_CNT consecutive all-high cycles -> idx advanced, go SCAN; any low bit -> back to HELD.
REQ-023 No auto-repeat: a held key SHALL produce exactly one KeyValid.
REQ-024 Clear SHALL set Value and Count to 0 next edge, in any FSM state, without affecting the FSM.
REQ-025 Clear and KeyValid in the same cycle: Clear wins; Value = 0, Count = 0, KeyCode still updates.
REQ-026 Worst-case press-to-KeyValid latency: 4*SCAN_DIV + DEBOUNCE_CNT + 2 cycles.

Reset
REQ-027 Reset asserted SHALL immediately force: state SCAN, idx 0, Row 4'b1110, KeyValid 0, KeyCode 0, Value 0, Count 0, synchronizer flops 4'b1111, all counters 0.
REQ-028 Reset mid-DEBOUNCE or mid-HELD SHALL discard the pending key without any KeyValid; after release the key is re-detected as a new press.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-029 Reset, no key -> Row cycles 1110,1101,1011,0111,1110 every 4 clocks; KeyValid never asserts.
REQ-030 Hold Col=1011 only while Row=1101 -> one KeyValid, KeyCode=4'h6, Value=16'h0006, Count=1; holding 200 cycles gives no second pulse.
REQ-031 Press keys 1,2,3,4,5 (each held then released) -> Value 16'h0001, 0012, 0123, 1234, 2345; Count ends at 4.
REQ-032 Bounce: Col low 2 cycles, high 1, low stable -> no pulse on the glitch, exactly one KeyValid after stable; release bounce gives no extra pulse.
REQ-033 Col=1001 (two keys on one row) -> no KeyValid; Clear pulsed in KeyValid cycle -> Value 0, Count 0, KeyCode updated.
REQ-034 Assert Reset during HELD -> outputs at reset values same cycle; after release and re-press -> exactly one KeyValid.
